// File: rtl/fifo_frame_reader_if.sv
// FIFO read port plus framed valid/ready output stream of fifo_frame_reader.
// master: the frame reader; slave: the FIFO/consumer side.
interface fifo_frame_reader_if #(
   parameter int unsigned DW    = 8,
   parameter int unsigned CNT_W = 8
);
   logic             e;
   logic             RREQ;
   logic [DW-1:0]    RD;
   logic             out_valid;
   logic             out_ready;
   logic [DW-1:0]    out_data;
   logic             out_last;
   logic [CNT_W-1:0] frame_cnt;

   modport master (
      input  e, RD, out_ready,
      output RREQ, out_valid, out_data, out_last, frame_cnt
   );

   modport slave (
      output e, RD, out_ready,
      input  RREQ, out_valid, out_data, out_last, frame_cnt
   );
endinterface

// File: rtl/fifo_frame_reader.sv
// Pops FIFO words one at a time and re-emits them as FRAME_LEN-word frames.
// Define FRAME_CHECKSUM_EN to append an XOR checksum word to every frame.
module fifo_frame_reader #(
   parameter int unsigned DW        = 8,
   parameter int unsigned FRAME_LEN = 4,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_frame_reader_if.master  bus
);

   localparam int unsigned WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [WC_W-1:0] LAST_IDX = WC_W'(FRAME_LEN - 1);

`ifdef FRAME_CHECKSUM_EN
   typedef enum logic [1:0] {S_FETCH, S_LATCH, S_SEND, S_CSUM} state_t;
`else
   typedef enum logic [1:0] {S_FETCH, S_LATCH, S_SEND} state_t;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [DW-1:0]    hold;
   logic [WC_W-1:0]  word_cnt;
   logic [CNT_W-1:0] frame_cnt;
`ifdef FRAME_CHECKSUM_EN
   logic [DW-1:0]    csum;
`endif

   logic             rreq_c;
   logic             valid_c;
   logic [DW-1:0]    data_c;
   logic             last_c;
   logic             last_word_c;

   assign last_word_c = (word_cnt == LAST_IDX);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH: if (!bus.e) state_nxt = S_LATCH;
         S_LATCH: state_nxt = S_SEND;
         S_SEND: begin
            if (bus.out_ready) begin
`ifdef FRAME_CHECKSUM_EN
               state_nxt = last_word_c ? S_CSUM : S_FETCH;
`else
               state_nxt = S_FETCH;
`endif
            end
         end
`ifdef FRAME_CHECKSUM_EN
         S_CSUM: if (bus.out_ready) state_nxt = S_FETCH;
`endif
         default: state_nxt = S_FETCH;
      endcase
   end

   // Output decode: only FETCH requests, so at most one word is ever in flight
   always_comb begin
      rreq_c  = 1'b0;
      valid_c = 1'b0;
      data_c  = '0;
      last_c  = 1'b0;
      case (state)
         S_FETCH: rreq_c = !bus.e;
         S_SEND: begin
            valid_c = 1'b1;
            data_c  = hold;
`ifndef FRAME_CHECKSUM_EN
            last_c  = last_word_c;
`endif
         end
`ifdef FRAME_CHECKSUM_EN
         S_CSUM: begin
            valid_c = 1'b1;
            data_c  = csum;
            last_c  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Datapath: captured word, running checksum, word and frame counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= '0;
         word_cnt  <= '0;
         frame_cnt <= '0;
`ifdef FRAME_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         case (state)
            S_LATCH: begin
               hold <= bus.RD;
`ifdef FRAME_CHECKSUM_EN
               csum <= csum ^ bus.RD;
`endif
            end
            S_SEND: begin
               if (bus.out_ready) begin
                  if (last_word_c) begin
                     word_cnt  <= '0;
`ifndef FRAME_CHECKSUM_EN
                     frame_cnt <= frame_cnt + CNT_W'(1);
`endif
                  end else begin
                     word_cnt <= word_cnt + WC_W'(1);
                  end
               end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CSUM: begin
               if (bus.out_ready) begin
                  csum      <= '0;
                  frame_cnt <= frame_cnt + CNT_W'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.RREQ      = rreq_c;
   assign bus.out_valid = valid_c;
   assign bus.out_data  = data_c;
   assign bus.out_last  = last_c;
   assign bus.frame_cnt = frame_cnt;

endmodule
